i2c_slave: RTL and testbench
============================

# i2c_slave

I2C target (slave) endpoint for the I2C peripheral. It is the counterpart of the team's I2C master and attaches to the same open-drain `sda`/`scl` bus. It oversamples the bus with the system clock, detects START/STOP, matches a fixed 7-bit address and ACKs it. On writes it delivers received bytes to local logic; on reads it shifts out bytes supplied by local logic.

## Interface
- `ADDR_BIT`, 7: address width; only 7 is supported.
- `SLAVE_ADDR`, 7'h42: own bus address.
- `SYNC_STAGES`, 2: flip-flop synchronizer depth on `scl` and `sda`; must be ≥2.

- `clk` input 1: system clock; must be ≥16× the SCL rate.
- `reset` input 1: asynchronous, active-low reset.
- `sda` inout 1: open-drain bus data; the block drives only 0 or z.
- `scl` inout 1: open-drain bus clock; driven low only by the stretch feature, otherwise always z.
- `r_data` output 8: last byte received from the host.
- `r_valid` output 1: one-clk pulse; `r_data` is valid in that cycle.
- `t_data` input 8: next byte to transmit.
- `t_req` output 1: one-clk pulse requesting the next transmit byte.
- `t_load` input 1: transmit byte ready. Used only with the stretch feature.
- `busy` output 1: high from an address match until the next STOP or START.

## Operation
- The block samples synchronized `scl_s`/`sda_s` and the previous-cycle copies. SCL rise and fall are single-cycle edge strobes.
- START is `sda_s` 1→0 while `scl_s`=1. STOP is `sda_s` 0→1 while `scl_s`=1.
- States (3-bit): IDLE, ADDR, ACK_ADDR, WR, ACK_WR, RD, ACK_RD, WAIT_STOP.
- START in any state → ADDR, bit counter cleared. This also covers repeated START.
- STOP in any state → IDLE. `sda` and `scl` are released and `busy`=0.
- ADDR: shift 8 bits MSB-first on SCL rise.
  - If bits[7:1]==SLAVE_ADDR → ACK_ADDR and `busy`=1.
  - Otherwise → WAIT_STOP, with `sda` never driven.
- ACK_ADDR: drive `sda` low from the SCL fall after bit 8 until the SCL fall after the 9th clock.
  - Then → WR if R/W=0, or RD if R/W=1.
- WR: shift 8 bits on SCL rise. After the 8th rise, `r_data` is updated and `r_valid` pulses once. Then → ACK_WR.
- ACK_WR: ACK as in ACK_ADDR, then → WR.
- RD:
  - On the SCL fall that ends ACK_ADDR or ACK_RD, `t_req` pulses and `t_data` is captured in the same cycle.
  - Bit 7 is placed on `sda` immediately. Each later bit changes on SCL fall.
  - A 1 bit is driven as z.
  - After the 8th bit's fall, `sda` is released → ACK_RD.
- ACK_RD: sample `sda_s` on SCL rise.
  - 0 (ACK) → RD, with the next byte requested at the following fall.
  - 1 (NACK) → WAIT_STOP.
- WAIT_STOP: `sda` released; ignore the bus until START or STOP.

## Timing
- Reset (`reset`=0, asynchronous): state IDLE, `r_data`=8'h00, `r_valid`=0, `t_req`=0, `busy`=0, `sda`=z, `scl`=z. Synchronizers are preset to 1.
- Bus-to-decision latency is SYNC_STAGES+1 clk after a pad transition.
- `sda` output changes occur 1 clk after the SCL-fall strobe. They are never on an SCL rise.
- `r_valid` asserts 1 clk after the 8th SCL-rise strobe of a data byte.
- A START or STOP mid-byte discards the partial byte. No `r_valid` or `t_req` is issued for it.
- Simultaneous START and SCL edge in one clk: START wins.
- A reset during a drive releases the bus within the same clk (asynchronous path).

## Configuration
- `I2C_SLAVE_CLK_STRETCH_EN`.
  - Defined:
    - After a `t_req` pulse, the block drives `scl` low and stays in RD until `t_load`=1.
    - `t_data` is captured on the `t_load` cycle.
    - Bit 7 is placed on `sda`, and `scl` is released 1 clk later.
    - STOP, START or reset during a stretch releases `scl` immediately.
  - Undefined: `t_load` is ignored, `scl` is permanently z, and `t_data` is captured on the `t_req` cycle.

## Test plan
- Host writes address 0x42+W, then 0xA5, then STOP → ACK on both 9th clocks; one `r_valid` with `r_data`=0xA5; `busy` 1→0 at STOP.
- Host writes address 0x43+W and 0x11 → `sda` z on every clock, no `r_valid`, `busy` stays 0.
- Host reads from 0x42 with `t_data`=0x3C then 0xC3; host ACKs byte 1 and NACKs byte 2 → bus bits 0x3C, 0xC3; two `t_req` pulses; WAIT_STOP then IDLE.
- Write 0x42+W and 0x5A, repeated START, then read 0x42+R → `r_data`=0x5A, then one `t_req` pulse and a correct ACK on the read address.
- Reset asserted after 4 bits of a data byte → all outputs return to reset values at once; a subsequent full transfer of 0x42+W and 0x77 succeeds.
- With `I2C_SLAVE_CLK_STRETCH_EN`: read from 0x42, `t_load` delayed 50 clk with `t_data`=0x81 → `scl` held low 50 clk, then 0x81 is transmitted.

Source files
------------

// File: rtl/i2c_slave.sv
`default_nettype none
// ============================================================================
//  Module   : i2c_slave
//  Purpose  : I2C target endpoint. It oversamples the open-drain SDA/SCL bus
//             with the system clock, detects START/STOP, matches a fixed
//             7-bit address and ACKs it. Bytes written by the host go out on
//             r_data/r_valid. Bytes read by the host are requested from local
//             logic with t_req and supplied on t_data.
//  Ports    : clk      - system clock, at least 16x the SCL rate
//             reset    - asynchronous active-low reset
//             sda      - open-drain bus data (driven 0 or z only)
//             scl      - open-drain bus clock (driven low only when stretching)
//             r_data   - last byte received from the host
//             r_valid  - one-clk strobe qualifying r_data
//             t_data   - next byte to transmit
//             t_req    - one-clk strobe requesting the next transmit byte
//             t_load   - transmit byte ready (clock-stretch build only)
//             busy     - addressed, from the address match until STOP/START
//  Options  : define I2C_SLAVE_CLK_STRETCH_EN to hold SCL low after each
//             t_req until local logic answers with t_load.
//  Revision : 1.0 - initial release
// ============================================================================
module i2c_slave #(
  parameter int                  ADDR_BIT    = 7,
  parameter logic [ADDR_BIT-1:0] SLAVE_ADDR  = 7'h42,
  parameter int                  SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  inout  wire        sda,
  inout  wire        scl,
  output logic [7:0] r_data,
  output logic       r_valid,
  input  logic [7:0] t_data,
  output logic       t_req,
  input  logic       t_load,
  output logic       busy
);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ADDR      = 3'd1,
    ST_ACK_ADDR  = 3'd2,
    ST_WR        = 3'd3,
    ST_ACK_WR    = 3'd4,
    ST_RD        = 3'd5,
    ST_ACK_RD    = 3'd6,
    ST_WAIT_STOP = 3'd7
  } state_t;

  // RD sub-phases encoded in the bit counter beyond the 0..7 bit range.
  localparam logic [3:0] C_RD_WAIT_FALL = 4'd8;   // ACKed, next byte loads on fall
  localparam logic [3:0] C_RD_STRETCH   = 4'd9;   // SCL held low, waiting t_load
  localparam logic [3:0] C_RD_RELEASE   = 4'd10;  // bit 7 on SDA, free SCL next

  // Bus synchronizers, preset to the idle (released) level.
  logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
  logic                   scl_prev_q, sda_prev_q;
  logic                   scl_s, sda_s;
  logic                   scl_rise, scl_fall, start_det, stop_det;

  state_t     state_q, state_d;
  logic [3:0] bitcnt_q, bitcnt_d;
  logic [6:0] shift_q, shift_d;     // first 7 bits of the byte in flight
  logic [6:0] tx_q, tx_d;           // transmit bits still to be presented
  logic       rw_q, rw_d;
  logic [7:0] r_data_q, r_data_d;
  logic       r_valid_q, r_valid_d;
  logic       busy_q, busy_d;
  logic       sda_oe_q, sda_oe_d;   // 1 = pull SDA low
  logic       load_tx;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl};
      sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda};
      scl_prev_q <= scl_s;
      sda_prev_q <= sda_s;
    end
  end

  assign scl_s     = scl_sync_q[SYNC_STAGES-1];
  assign sda_s     = sda_sync_q[SYNC_STAGES-1];
  assign scl_rise  = scl_s & ~scl_prev_q;
  assign scl_fall  = ~scl_s & scl_prev_q;
  assign start_det = scl_s & sda_prev_q & ~sda_s;
  assign stop_det  = scl_s & ~sda_prev_q & sda_s;

`ifdef I2C_SLAVE_CLK_STRETCH_EN
  logic scl_oe_q, scl_oe_d;
`else
  logic unused_t_load;
  assign unused_t_load = t_load;
`endif

  always_comb begin
    state_d   = state_q;
    bitcnt_d  = bitcnt_q;
    shift_d   = shift_q;
    tx_d      = tx_q;
    rw_d      = rw_q;
    r_data_d  = r_data_q;
    r_valid_d = 1'b0;
    busy_d    = busy_q;
    sda_oe_d  = sda_oe_q;
    t_req     = 1'b0;
    load_tx   = 1'b0;
`ifdef I2C_SLAVE_CLK_STRETCH_EN
    scl_oe_d  = scl_oe_q;
`endif
    // START/STOP take priority over any SCL edge seen in the same cycle and
    // abandon whatever partial byte was in progress.
    if (stop_det || start_det) begin
      state_d  = stop_det ? ST_IDLE : ST_ADDR;
      bitcnt_d = '0;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
`ifdef I2C_SLAVE_CLK_STRETCH_EN
      scl_oe_d = 1'b0;
`endif
    end else begin
      case (state_q)
        ST_IDLE, ST_WAIT_STOP: sda_oe_d = 1'b0;
        ST_ADDR: if (scl_rise) begin
          shift_d  = {shift_q[5:0], sda_s};
          bitcnt_d = bitcnt_q + 4'd1;
          if (bitcnt_q == 4'd7) begin
            bitcnt_d = '0;
            if (shift_q == SLAVE_ADDR) begin
              state_d = ST_ACK_ADDR;
              busy_d  = 1'b1;
              rw_d    = sda_s;
            end else begin
              state_d = ST_WAIT_STOP;
            end
          end
        end
        // First fall starts the ACK pulse, the fall after the 9th clock ends it.
        ST_ACK_ADDR, ST_ACK_WR: if (scl_fall) begin
          if (!sda_oe_q) begin
            sda_oe_d = 1'b1;
          end else begin
            sda_oe_d = 1'b0;
            if (state_q == ST_ACK_WR || !rw_q) begin
              state_d  = ST_WR;
              bitcnt_d = '0;
            end else begin
              state_d = ST_RD;
              load_tx = 1'b1;
            end
          end
        end
        ST_WR: if (scl_rise) begin
          shift_d  = {shift_q[5:0], sda_s};
          bitcnt_d = bitcnt_q + 4'd1;
          if (bitcnt_q == 4'd7) begin
            r_data_d  = {shift_q, sda_s};
            r_valid_d = 1'b1;
            bitcnt_d  = '0;
            state_d   = ST_ACK_WR;
          end
        end
        ST_RD: begin
          if (bitcnt_q == C_RD_WAIT_FALL) begin
            load_tx = scl_fall;
`ifdef I2C_SLAVE_CLK_STRETCH_EN
          end else if (bitcnt_q == C_RD_STRETCH) begin
            if (t_load) begin
              tx_d     = t_data[6:0];
              sda_oe_d = ~t_data[7];
              bitcnt_d = C_RD_RELEASE;
            end
          end else if (bitcnt_q == C_RD_RELEASE) begin
            scl_oe_d = 1'b0;
            bitcnt_d = '0;
`endif
          end else if (scl_fall) begin
            if (bitcnt_q == 4'd7) begin
              sda_oe_d = 1'b0;
              state_d  = ST_ACK_RD;
            end else begin
              sda_oe_d = ~tx_q[6];
              tx_d     = {tx_q[5:0], 1'b0};
              bitcnt_d = bitcnt_q + 4'd1;
            end
          end
        end
        ST_ACK_RD: if (scl_rise) begin
          if (!sda_s) begin
            state_d  = ST_RD;
            bitcnt_d = C_RD_WAIT_FALL;
          end else begin
            state_d = ST_WAIT_STOP;
          end
        end
        default: state_d = ST_IDLE;
      endcase
      if (load_tx) begin
        t_req = 1'b1;
`ifdef I2C_SLAVE_CLK_STRETCH_EN
        scl_oe_d = 1'b1;
        bitcnt_d = C_RD_STRETCH;
`else
        tx_d     = t_data[6:0];
        sda_oe_d = ~t_data[7];
        bitcnt_d = '0;
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      bitcnt_q  <= '0;
      shift_q   <= '0;
      tx_q      <= '0;
      rw_q      <= 1'b0;
      r_data_q  <= 8'h00;
      r_valid_q <= 1'b0;
      busy_q    <= 1'b0;
      sda_oe_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      bitcnt_q  <= bitcnt_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
      rw_q      <= rw_d;
      r_data_q  <= r_data_d;
      r_valid_q <= r_valid_d;
      busy_q    <= busy_d;
      sda_oe_q  <= sda_oe_d;
    end
  end

`ifdef I2C_SLAVE_CLK_STRETCH_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) scl_oe_q <= 1'b0;
    else        scl_oe_q <= scl_oe_d;
  end
  assign scl = scl_oe_q ? 1'b0 : 1'bz;
`else
  assign scl = 1'bz;
`endif

  assign sda     = sda_oe_q ? 1'b0 : 1'bz;
  assign r_data  = r_data_q;
  assign r_valid = r_valid_q;
  assign busy    = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_i2c_slave.sv
`default_nettype none
// ============================================================================
//  Module   : tb_i2c_slave
//  Purpose  : Bus-level host model driving i2c_slave with directed and random
//             transfers; received and requested bytes are scoreboarded.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_i2c_slave;
  localparam int Q = 6;  // clocks per quarter SCL period

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       h_sda_low = 1'b0, h_scl_low = 1'b0;
  logic [7:0] r_data, t_data;
  logic       r_valid, t_req, busy;
  logic       t_load = 1'b0;
  tri1        sda, scl;

  int errors = 0, checks = 0;
  logic [7:0] exp_rx[$];   // bytes the DUT must deliver on r_valid
  logic [7:0] tx_src[$];   // bytes local logic will hand over on t_req
  logic [7:0] wdat[$], rdat[$];

  always #5 clk = ~clk;
  assign sda = h_sda_low ? 1'b0 : 1'bz;
  assign scl = h_scl_low ? 1'b0 : 1'bz;

  i2c_slave #(.ADDR_BIT(7), .SLAVE_ADDR(7'h42), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset_n), .sda(sda), .scl(scl),
    .r_data(r_data), .r_valid(r_valid), .t_data(t_data),
    .t_req(t_req), .t_load(t_load), .busy(busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic refresh_tdata();
    t_data = (tx_src.size() > 0) ? tx_src[0] : 8'h00;
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic scl_release();
    int n;
    n = 0;
    h_scl_low = 1'b0;
    while (scl !== 1'b1 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) begin
      checks++;
      errors++;
      $display("FAIL scl_release: scl still low after %0d clk", n);
    end
  endtask

  task automatic start_cond();
    h_sda_low = 1'b0; tick(Q);
    scl_release();    tick(Q);
    h_sda_low = 1'b1; tick(Q);
    h_scl_low = 1'b1; tick(Q);
  endtask

  task automatic stop_cond();
    h_sda_low = 1'b1; tick(Q);
    scl_release();    tick(Q);
    h_sda_low = 1'b0; tick(Q);
  endtask

  // Host writes b (1 = release) and samples the bus in the SCL-high window.
  task automatic bit_xfer(input logic b, output logic s);
    h_sda_low = ~b; tick(Q);
    scl_release();  tick(Q);
    s = sda;        tick(Q);
    h_scl_low = 1'b1; tick(Q);
  endtask

  task automatic byte_w(input logic [7:0] d, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) bit_xfer(d[i], s);
    bit_xfer(1'b1, ack);
  endtask

  task automatic byte_r(input logic nack, output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      bit_xfer(1'b1, s);
      d[i] = s;
    end
    bit_xfer(nack, s);
  endtask

  task automatic wr_xfer(input logic [6:0] a, input bit do_stop);
    logic ack;
    bit   hit;
    hit = (a == 7'h42);
    start_cond();
    byte_w({a, 1'b0}, ack);
    check("addr_ack_w", ack, hit ? 0 : 1);
    check("busy_after_addr_w", busy, hit);
    foreach (wdat[i]) begin
      if (hit) exp_rx.push_back(wdat[i]);
      byte_w(wdat[i], ack);
      check("data_ack_w", ack, hit ? 0 : 1);
    end
    wdat.delete();
    if (do_stop) begin
      stop_cond();
      check("busy_after_stop_w", busy, 0);
    end
  endtask

  task automatic rd_xfer(input logic [6:0] a);
    logic       ack;
    logic [7:0] d;
    bit         hit;
    hit = (a == 7'h42);
    if (hit) foreach (rdat[i]) tx_src.push_back(rdat[i]);
    refresh_tdata();
    start_cond();
    byte_w({a, 1'b1}, ack);
    check("addr_ack_r", ack, hit ? 0 : 1);
    check("busy_after_addr_r", busy, hit);
    if (hit) foreach (rdat[i]) begin
      byte_r(i == rdat.size() - 1, d);
      check("rd_byte", d, rdat[i]);
    end
    rdat.delete();
    stop_cond();
    check("busy_after_stop_r", busy, 0);
  endtask

  // Receive-side scoreboard and (non-stretch) transmit-request tracker.
  initial begin
    forever begin
      @(negedge clk);
      if (r_valid) begin
        if (exp_rx.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL r_valid_unexpected: got data %02h, no byte expected", r_data);
        end else begin
          logic [7:0] e;
          e = exp_rx.pop_front();
          check("r_data", r_data, e);
        end
      end
`ifndef I2C_SLAVE_CLK_STRETCH_EN
      if (t_req) begin
        checks++;
        if (tx_src.size() == 0) begin
          errors++;
          $display("FAIL t_req_unexpected: got request, no byte expected");
        end else begin
          @(posedge clk);
          #1;
          void'(tx_src.pop_front());
          refresh_tdata();
        end
      end
`endif
    end
  end

`ifdef I2C_SLAVE_CLK_STRETCH_EN
  int stretch_dly = 5;
  int lows;
  // Local-logic responder: answers each request after stretch_dly clocks.
  initial begin
    forever begin
      @(negedge clk);
      if (t_req) begin
        checks++;
        if (tx_src.size() == 0) begin
          errors++;
          $display("FAIL t_req_unexpected: got request, no byte expected");
        end else begin
          lows = 0;
          for (int k = 0; k < stretch_dly; k++) begin
            @(negedge clk);
            if (scl === 1'b0) lows++;
          end
          check("stretch_low_clks", lows, stretch_dly);
          t_data = tx_src[0];
          t_load = 1'b1;
          @(negedge clk);
          t_load = 1'b0;
          void'(tx_src.pop_front());
          refresh_tdata();
          repeat (3) @(negedge clk);
          check("scl_released_after_load", scl, 1);
        end
      end
    end
  end
`endif

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [6:0] a;
    int         n;
    logic       ack, s;
    t_data = 8'h00;
    tick(3);
    check("rst_r_data", r_data, 8'h00);
    check("rst_r_valid", r_valid, 0);
    check("rst_t_req", t_req, 0);
    check("rst_busy", busy, 0);
    check("rst_sda", sda, 1);
    check("rst_scl", scl, 1);
    reset_n = 1'b1;
    tick(4);

    wdat.push_back(8'hA5);
    wr_xfer(7'h42, 1'b1);
    check("r_data_a5", r_data, 8'hA5);

    wdat.push_back(8'h11);
    wr_xfer(7'h43, 1'b1);
    check("r_data_kept", r_data, 8'hA5);

    rdat.push_back(8'h3C);
    rdat.push_back(8'hC3);
    rd_xfer(7'h42);

    // Write then repeated START into a read.
    wdat.push_back(8'h5A);
    wr_xfer(7'h42, 1'b0);
    rdat.push_back(8'($urandom));
    rd_xfer(7'h42);
    check("r_data_5a", r_data, 8'h5A);

    // Asynchronous reset four bits into a data byte.
    start_cond();
    byte_w({7'h42, 1'b0}, ack);
    check("addr_ack_pre_reset", ack, 0);
    bit_xfer(1'b1, s); bit_xfer(1'b0, s); bit_xfer(1'b1, s); bit_xfer(1'b1, s);
    h_sda_low = 1'b0;
    reset_n = 1'b0;
    #1;
    check("mid_rst_r_data", r_data, 8'h00);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_r_valid", r_valid, 0);
    check("mid_rst_sda", sda, 1);
    h_scl_low = 1'b0;
    tick(4);
    reset_n = 1'b1;
    tick(4);
    wdat.push_back(8'h77);
    wr_xfer(7'h42, 1'b1);
    check("r_data_77", r_data, 8'h77);

`ifdef I2C_SLAVE_CLK_STRETCH_EN
    stretch_dly = 50;
    rdat.push_back(8'h81);
    rd_xfer(7'h42);
    stretch_dly = 5;
`endif

    for (int it = 0; it < 10; it++) begin
      a = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(0, 127)) : 7'h42;
      if (a == 7'h40) a = 7'h41;
      n = $urandom_range(1, 3);
      if ($urandom_range(0, 1) == 1) begin
        for (int k = 0; k < n; k++) wdat.push_back(8'($urandom));
        wr_xfer(a, 1'b1);
      end else begin
        for (int k = 0; k < n; k++) rdat.push_back(8'($urandom));
        rd_xfer(a);
      end
    end

    tick(20);
    check("rx_queue_drained", exp_rx.size(), 0);
    check("tx_queue_drained", tx_src.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
